multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle control FSM for the MIPS core. It replaces the single-cycle opcode decoder when the datapath shares one memory and one ALU across cycles. It sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq and j. It also handles a ready handshake with the shared memory and flags illegal opcodes and memory timeouts.

Parameters:
MEM_WAIT_MAX, 15, maximum consecutive cycles a memory state waits for mem_ready before abort (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction bits [31:26] from IR, stable from DECODE until return to FETCH
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current read/write this cycle
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
iord  output  1  0=PC address, 1=ALUOut address
ir_write  output  1  load IR
reg_write  output  1  register file write enable
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  output  1  PC load = pc_write | (pc_write_cond & zero)
state  output  4  current state encoding (debug)
illegal_op  output  1  sticky illegal-opcode flag
mem_timeout  output  1  sticky memory-timeout flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- States/encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10. Unlisted encodings -> IDLE.
- Reset (async, rst_n=0): state=IDLE; illegal_op=0; mem_timeout=0; retired=0; wait counter=0. All control outputs are decoded from state and are 0 in IDLE.
- Reset mid-operation: immediate return to IDLE; no strobe survives reset.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- Default for every control output not listed for a state: 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready (Mealy). Moves to DECODE on mem_ready, else holds.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 35 or 43 -> MEM_ADDR
  - 0 -> R_EXEC
  - 4 -> BRANCH
  - 2 -> JUMP
  - other -> FETCH, with illegal_op set (sticky)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD if opcode=35, else MEM_WR.
- MEM_RD: mem_read=1, iord=1. Moves to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEM_WR: mem_write=1, iord=1. Moves to FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1. Next is FETCH.
- JUMP: pc_source=10, pc_write=1. Next is FETCH.
- Latency in cycles with zero-wait memory (fetch to next fetch):
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - j 3
- Wait counter (8 bits):
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle those states see mem_ready=0.
  - When the count equals MEM_WAIT_MAX and mem_ready=0: set mem_timeout (sticky), force FETCH, suppress ir_write/pc_write/reg_write that cycle.
  - mem_ready=1 on the same cycle the limit is reached counts as success.
- Sticky flags clear only on reset.

Optional Feature:
CTRL_RETIRE_CNT_EN
- Defined: retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WR (mem_ready=1), R_WB, BRANCH or JUMP. Wraps at 2^CNT_W-1 -> 0.
- Illegal-opcode and timeout aborts do not count.
- Not defined: retired is constant 0 and no counter flops exist.

Test Plan:
- Reset mid-MEM_RD with mem_ready=0 -> state=0 immediately, all strobes 0; FETCH one cycle after rst_n rises.
- lw, mem_ready=1 always -> states 1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in state 5. retired +1 (feature on).
- sw, mem_ready held 0 for 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, iord=1, then FETCH, retired +1.
- beq with zero=1 then zero=0 -> pc_en=1 with pc_source=01 in first BRANCH; pc_en=0 in second.
- opcode=6'd63 -> DECODE->FETCH, illegal_op=1 stays set; retired unchanged; next valid instruction executes normally.
- MEM_WAIT_MAX=3, mem_ready=0 in FETCH -> mem_timeout=1 on 4th wait cycle, ir_write never asserted, state returns to FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback for R-type, lw, sw, beq and j over a shared memory and ALU, with a mem_ready
// handshake, a per-access wait limit and sticky error flags.
//
// Optional feature macro: CTRL_RETIRE_CNT_EN (retired-instruction counter). When undefined,
// retired is tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode[5:0]           IR[31:26], stable from DECODE until the return to FETCH
//   zero                  ALU zero flag (branch condition)
//   mem_ready             shared memory completes the current access this cycle
//   mem_read, mem_write   memory strobes; iord selects PC (0) or ALUOut (1) address
//   ir_write, reg_write   IR load, register file write enable
//   reg_dst, mem_to_reg   write register select (rt/rd), write data select (ALUOut/MDR)
//   alu_src_a, alu_src_b  ALU operand selects; alu_op 00=add 01=sub 10=funct
//   pc_source, pc_en      PC source select and PC load enable
//   state[3:0]            current state encoding (debug)
//   illegal_op            sticky unknown-opcode flag
//   mem_timeout           sticky memory-wait-limit flag
//   retired[CNT_W-1:0]    retired-instruction count
module multicycle_control #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             pc_en,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StMemAddr = 4'd3,
      StMemRd   = 4'd4,
      StMemWb   = 4'd5,
      StMemWr   = 4'd6,
      StRExec   = 4'd7,
      StRWb     = 4'd8,
      StBranch  = 4'd9,
      StJump    = 4'd10
   } state_e;

   localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

   state_e     r_state;
   state_e     w_next;
   logic [7:0] r_wait;
   logic [7:0] w_wait_next;
   logic       r_illegal;
   logic       r_timeout;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_set_illegal;
   logic       w_mem_state;
   logic       w_at_limit;
   logic       w_enter_wait;

   // States that wait on the shared memory handshake.
   assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
   // Limit reached with no completion: abort. mem_ready on the limit cycle still succeeds.
   assign w_at_limit  = w_mem_state && !mem_ready && (r_wait == WaitMax);

   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      iord            = 1'b0;
      ir_write        = 1'b0;
      reg_write       = 1'b0;
      reg_dst         = 1'b0;
      mem_to_reg      = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      alu_op          = 2'b00;
      pc_source       = 2'b00;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_set_illegal   = 1'b0;
      w_next          = r_state;

      case (r_state)
         StIdle: w_next = StFetch;
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write   = 1'b1;
               w_pc_write = 1'b1;
               w_next     = StDecode;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            case (opcode)
               6'd35, 6'd43: w_next = StMemAddr;
               6'd0:         w_next = StRExec;
               6'd4:         w_next = StBranch;
               6'd2:         w_next = StJump;
               default: begin
                  w_next        = StFetch;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = (opcode == 6'd35) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) w_next = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = StFetch;
         end
         StMemWr: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) w_next = StFetch;
         end
         StRExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            w_next    = StRWb;
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            w_next    = StFetch;
         end
         StBranch: begin
            alu_src_a       = 1'b1;
            alu_op          = 2'b01;
            pc_source       = 2'b01;
            w_pc_write_cond = 1'b1;
            w_next          = StFetch;
         end
         StJump: begin
            pc_source  = 2'b10;
            w_pc_write = 1'b1;
            w_next     = StFetch;
         end
         default: w_next = StIdle;
      endcase

      if (w_at_limit) begin
         w_next     = StFetch;
         ir_write   = 1'b0;
         w_pc_write = 1'b0;
         reg_write  = 1'b0;
      end
   end

   // A timeout re-enters FETCH from FETCH; treat that as a fresh entry so the count restarts.
   assign w_enter_wait = ((w_next == StFetch) || (w_next == StMemRd) || (w_next == StMemWr)) &&
                         ((w_next != r_state) || w_at_limit);

   always_comb begin
      w_wait_next = r_wait;
      if (w_enter_wait) begin
         w_wait_next = 8'd0;
      end else if (w_mem_state && !mem_ready) begin
         w_wait_next = r_wait + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_wait    <= 8'd0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         if (w_set_illegal) r_illegal <= 1'b1;
         if (w_at_limit)    r_timeout <= 1'b1;
      end
   end

   assign pc_en       = w_pc_write | (w_pc_write_cond & zero);
   assign state       = r_state;
   assign illegal_op  = r_illegal;
   assign mem_timeout = r_timeout;

`ifdef CTRL_RETIRE_CNT_EN
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;

   // Only normal completions count; aborts (illegal opcode, timeout) never reach these arcs.
   assign w_retire = (w_next == StFetch) && !w_at_limit &&
                     ((r_state == StMemWb) || (r_state == StRWb) || (r_state == StBranch) ||
                      (r_state == StJump) || ((r_state == StMemWr) && mem_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign retired = r_retired;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int unsigned MaxW = 3;
   localparam int unsigned CntW = 4;
`ifdef CTRL_RETIRE_CNT_EN
   localparam int RetOn = 1;
`else
   localparam int RetOn = 0;
`endif

   localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAddr = 4'd3;
   localparam logic [3:0] SMemRd = 4'd4, SMemWb = 4'd5, SMemWr = 4'd6, SRExec = 4'd7;
   localparam logic [3:0] SRWb = 4'd8, SBranch = 4'd9, SJump = 4'd10;

   logic            clk, rst_n, zero, mem_ready;
   logic [5:0]      opcode;
   logic            mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
   logic            alu_src_a, pc_en, illegal_op, mem_timeout;
   logic [1:0]      alu_src_b, alu_op, pc_source;
   logic [3:0]      state;
   logic [CntW-1:0] retired;
   logic [14:0]     dut_ctrl;

   int checks = 0;
   int failures = 0;

   multicycle_control #(.MEM_WAIT_MAX(MaxW), .CNT_W(CntW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .pc_en(pc_en), .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .retired(retired)
   );

   assign dut_ctrl = {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, alu_op, pc_source, pc_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Control outputs each state must present, straight from the per-state output list.
   function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                            input logic z);
      logic mr, mw, io, irw, rw, rd, m2r, asa, pce;
      logic [1:0] asb, aop, pcs;
      {mr, mw, io, irw, rw, rd, m2r, asa, pce, asb, aop, pcs} = '0;
      case (st)
         SFetch:   begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
         SDecode:  asb = 2'b11;
         SMemAddr: begin asa = 1; asb = 2'b10; end
         SMemRd:   begin mr = 1; io = 1; end
         SMemWb:   begin rw = 1; m2r = 1; end
         SMemWr:   begin mw = 1; io = 1; end
         SRExec:   begin asa = 1; aop = 2'b10; end
         SRWb:     begin rw = 1; rd = 1; end
         SBranch:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
         SJump:    begin pcs = 2'b10; pce = 1; end
         default:  ;
      endcase
      return {mr, mw, io, irw, rw, rd, m2r, asa, asb, aop, pcs, pce};
   endfunction

   // ---------------- instruction-level reference model ----------------
   typedef struct {logic [3:0] st; logic rdy;} cyc_t;
   cyc_t            q[$];
   logic            m_ill, m_tmo;
   logic [CntW-1:0] m_ret;

   task automatic push(input logic [3:0] st, input logic rdy);
      cyc_t c;
      c.st  = st;
      c.rdy = rdy;
      q.push_back(c);
   endtask

   // A memory access with w not-ready cycles: succeeds when w <= limit, else aborts
   // on the (limit+1)-th waiting cycle.
   task automatic mem_phase(input logic [3:0] st, input int w, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < w; i++) begin
         push(st, 1'b0);
         if (i == int'(MaxW)) begin
            ok    = 1'b0;
            m_tmo = 1'b1;
            return;
         end
      end
      push(st, 1'b1);
   endtask

   task automatic retire();
      if (RetOn != 0) m_ret = m_ret + CntW'(1);
   endtask

   task automatic plan(input logic [5:0] op, input int fw, input int dw);
      bit ok;
      mem_phase(SFetch, fw, ok);
      if (!ok) return;
      push(SDecode, 1'($urandom_range(0, 1)));
      case (op)
         6'd35: begin
            push(SMemAddr, 1'($urandom_range(0, 1)));
            mem_phase(SMemRd, dw, ok);
            if (ok) begin push(SMemWb, 1'($urandom_range(0, 1))); retire(); end
         end
         6'd43: begin
            push(SMemAddr, 1'($urandom_range(0, 1)));
            mem_phase(SMemWr, dw, ok);
            if (ok) retire();
         end
         6'd0: begin
            push(SRExec, 1'($urandom_range(0, 1)));
            push(SRWb, 1'($urandom_range(0, 1)));
            retire();
         end
         6'd4: begin push(SBranch, 1'($urandom_range(0, 1))); retire(); end
         6'd2: begin push(SJump, 1'($urandom_range(0, 1))); retire(); end
         default: m_ill = 1'b1;
      endcase
   endtask

   task automatic run_queue(input logic z, input int idx);
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         mem_ready = c.rdy;
         zero      = z;
         @(negedge clk);
         chk($sformatf("rnd%0d state", idx), state, c.st);
         chk($sformatf("rnd%0d ctrl", idx), dut_ctrl, exp_ctrl(c.st, c.rdy, z));
         @(posedge clk);
         #1;
      end
      chk($sformatf("rnd%0d end state", idx), state, SFetch);
      chk($sformatf("rnd%0d illegal", idx), illegal_op, m_ill);
      chk($sformatf("rnd%0d timeout", idx), mem_timeout, m_tmo);
      chk($sformatf("rnd%0d retired", idx), retired, m_ret);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [5:0]  op;
      logic        z;
      int          fw;
      int          dw;
      int          cyc;
      logic [47:0] trace;
      int          pce;
      int          mw;
      int          irw;
      int          ret;
      logic        ill;
      logic        tmo;
   } rec_t;

   rec_t tbl[11];

   task automatic run_rec(input rec_t r, input int idx);
      int              fl, dl, n, pcn, mwn, irn;
      logic [47:0]     tr;
      logic [3:0]      prev;
      logic [CntW-1:0] r0, dret;
      logic            t0;
      bit              done;
      fl = 0; dl = 0; n = 0; pcn = 0; mwn = 0; irn = 0; tr = '0; done = 1'b0;
      r0 = retired;
      t0 = mem_timeout;
      opcode = r.op;
      zero   = r.z;
      while (!done && n < 40) begin
         prev = state;
         if (state == SFetch) begin
            mem_ready = (fl >= r.fw);
            if (!mem_ready) fl++;
         end else if (state == SMemRd || state == SMemWr) begin
            mem_ready = (dl >= r.dw);
            if (!mem_ready) dl++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         tr  = {tr[43:0], state};
         pcn += int'(pc_en);
         mwn += int'(mem_write);
         irn += int'(ir_write);
         @(posedge clk);
         #1;
         n++;
         done = (state == SFetch) && ((prev != SFetch) || (mem_timeout && !t0));
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL rec%0d bound: no return to FETCH within %0d cycles", idx, n);
      end
      dret = retired - r0;
      chk($sformatf("rec%0d cycles", idx), n, r.cyc);
      chk($sformatf("rec%0d trace", idx), tr, r.trace);
      chk($sformatf("rec%0d pc_en count", idx), pcn, r.pce);
      chk($sformatf("rec%0d mem_write count", idx), mwn, r.mw);
      chk($sformatf("rec%0d ir_write count", idx), irn, r.irw);
      chk($sformatf("rec%0d retired delta", idx), dret, CntW'(r.ret * RetOn));
      chk($sformatf("rec%0d illegal", idx), illegal_op, r.ill);
      chk($sformatf("rec%0d timeout", idx), mem_timeout, r.tmo);
      m_ill = r.ill;
      m_tmo = r.tmo;
      if (r.ret != 0) retire();
   endtask

   initial begin
      //           op     z     fw dw cyc trace           pce mw irw ret ill   tmo
      tbl[0]  = '{6'd35, 1'b0, 0, 0, 5, 48'h12345,       1,  0, 1,  1, 1'b0, 1'b0};
      tbl[1]  = '{6'd43, 1'b0, 0, 3, 7, 48'h1236666,     1,  4, 1,  1, 1'b0, 1'b0};
      tbl[2]  = '{6'd0,  1'b0, 0, 0, 4, 48'h1278,        1,  0, 1,  1, 1'b0, 1'b0};
      tbl[3]  = '{6'd4,  1'b1, 0, 0, 3, 48'h129,         2,  0, 1,  1, 1'b0, 1'b0};
      tbl[4]  = '{6'd4,  1'b0, 0, 0, 3, 48'h129,         1,  0, 1,  1, 1'b0, 1'b0};
      tbl[5]  = '{6'd2,  1'b0, 0, 0, 3, 48'h12A,         2,  0, 1,  1, 1'b0, 1'b0};
      tbl[6]  = '{6'd63, 1'b0, 0, 0, 2, 48'h12,          1,  0, 1,  0, 1'b1, 1'b0};
      tbl[7]  = '{6'd35, 1'b0, 2, 1, 8, 48'h11123445,    1,  0, 1,  1, 1'b1, 1'b0};
      tbl[8]  = '{6'd0,  1'b0, 4, 0, 4, 48'h1111,        0,  0, 0,  0, 1'b1, 1'b1};
      tbl[9]  = '{6'd43, 1'b1, 0, 3, 7, 48'h1236666,     1,  4, 1,  1, 1'b1, 1'b1};
      tbl[10] = '{6'd35, 1'b0, 0, 4, 7, 48'h1234444,     1,  0, 1,  0, 1'b1, 1'b1};

      m_ill = 1'b0;
      m_tmo = 1'b0;
      m_ret = '0;
      rst_n = 1'b0;
      opcode = 6'd0;
      zero = 1'b0;
      mem_ready = 1'b0;

      // Reset state, then IDLE -> FETCH one cycle after release.
      #12;
      chk("reset state", state, SIdle);
      chk("reset ctrl", dut_ctrl, 15'd0);
      chk("reset flags", {illegal_op, mem_timeout}, 2'b00);
      chk("reset retired", retired, '0);
      #5 rst_n = 1'b1;
      @(negedge clk);
      chk("idle after release", state, SIdle);
      @(posedge clk);
      #1;
      chk("fetch after release", state, SFetch);

      for (int i = 0; i < 11; i++) run_rec(tbl[i], i);

      for (int i = 0; i < 50; i++) begin
         logic [5:0] op;
         int         sel, fw, dw;
         sel = $urandom_range(0, 5);
         case (sel)
            0: op = 6'd35;
            1: op = 6'd43;
            2: op = 6'd0;
            3: op = 6'd4;
            4: op = 6'd2;
            default: begin
               op = 6'($urandom_range(0, 63));
               if (op == 6'd35 || op == 6'd43 || op == 6'd0 || op == 6'd4 || op == 6'd2)
                  op = 6'd63;
            end
         endcase
         fw = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 2);
         dw = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
         opcode = op;
         plan(op, fw, dw);
         run_queue(1'($urandom_range(0, 1)), i);
      end

      // Reset while MEM_RD is waiting on memory.
      opcode = 6'd35;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #2;
      chk("pre-reset in MEM_RD", state, SMemRd);
      rst_n = 1'b0;
      #1;
      chk("async reset state", state, SIdle);
      chk("async reset strobes", {mem_read, mem_write, ir_write, reg_write, pc_en, iord}, 6'd0);
      chk("async reset flags", {illegal_op, mem_timeout}, 2'b00);
      chk("async reset retired", retired, '0);
      @(posedge clk); #1;
      chk("held in reset", state, SIdle);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("fetch after mid-op reset", state, SFetch);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
